// File: rtl/lr3_seq_logic.sv
// Hex-digit entry register for an 8-digit seven-segment display: shifts digits in and un-blanks positions.
// Optional 2-3-0-B detector that freezes the display until reset is compiled in with LR3_SEQ_DET_EN.
module lr3_seq_logic (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic [3:0]  DAT_I,
    output logic [31:0] DISP_SEQ,
    output logic [7:0]  DISP_OFF
);

    logic [31:0] seq_reg, seq_next;
    logic [7:0]  off_reg, off_next;
    logic        entry;

    // Newest digit lands in nibble 0; every older nibble moves up one position.
    assign seq_next[3:0] = DAT_I;
    assign off_next[0]   = 1'b0;

    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_shift
            assign seq_next[gi*4 +: 4] = seq_reg[(gi-1)*4 +: 4];
            assign off_next[gi]        = off_reg[gi-1];
        end
    endgenerate

`ifdef LR3_SEQ_DET_EN
    typedef enum logic [1:0] {
        IDLE,
        S2,
        S23,
        S230
    } det_state_t;

    det_state_t state_reg, state_next;
    logic       lock_reg, lock_next;

    assign entry = CE & ~lock_reg;

    // The detector only moves on accepted entries; a stray 2 always restarts the match.
    always_comb begin
        state_next = state_reg;
        lock_next  = lock_reg;
        if (entry) begin
            state_next = (DAT_I == 4'h2) ? S2 : IDLE;
            unique case (state_reg)
                IDLE: ;
                S2:   if (DAT_I == 4'h3) state_next = S23;
                S23:  if (DAT_I == 4'h0) state_next = S230;
                S230: if (DAT_I == 4'hB) begin
                    state_next = IDLE;
                    lock_next  = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            lock_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            lock_reg  <= lock_next;
        end
    end
`else
    assign entry = CE;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            seq_reg <= 32'h0000_0000;
            off_reg <= 8'hFF;
        end else if (entry) begin
            seq_reg <= seq_next;
            off_reg <= off_next;
        end
    end

    assign DISP_SEQ = seq_reg;
    assign DISP_OFF = off_reg;

endmodule

// File: tb/tb_lr3_seq_logic.sv
// Self-checking bench for lr3_seq_logic: directed cases plus biased random entry against a digit-history model.
// Expectations follow LR3_SEQ_DET_EN the same way the design does.
module tb_lr3_seq_logic;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CE  = 1'b0;
    logic [3:0]  DAT_I = 4'h0;
    logic [31:0] DISP_SEQ;
    logic [7:0]  DISP_OFF;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: the last (up to) 8 accepted digits since reset, oldest first, and the lock flag.
    logic [3:0] hist[$];
    bit         lock_m = 1'b0;

    lr3_seq_logic dut (
        .CLK      (CLK),
        .RST      (RST),
        .CE       (CE),
        .DAT_I    (DAT_I),
        .DISP_SEQ (DISP_SEQ),
        .DISP_OFF (DISP_OFF)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] model_seq();
        logic [31:0] s = 32'h0;
        foreach (hist[i]) s = (s << 4) | 32'(hist[i]);
        return s;
    endfunction

    function automatic logic [7:0] model_off();
        logic [7:0] o = 8'hFF;
        o = o << hist.size();
        return o;
    endfunction

    task automatic model_update(input logic rst, input logic ce, input logic [3:0] d);
        int n;
        if (rst) begin
            hist.delete();
            lock_m = 1'b0;
        end else if (ce && !lock_m) begin
            hist.push_back(d);
            if (hist.size() > 8) void'(hist.pop_front());
`ifdef LR3_SEQ_DET_EN
            n = hist.size();
            if (n >= 4 && hist[n-4] == 4'h2 && hist[n-3] == 4'h3 &&
                hist[n-2] == 4'h0 && hist[n-1] == 4'hB)
                lock_m = 1'b1;
`else
            n = 0;
`endif
        end
    endtask

    // One clock: drive, let the edge happen, then compare away from the edge.
    task automatic step(input string tag, input logic rst, input logic ce, input logic [3:0] d);
        RST = rst;
        CE = ce;
        DAT_I = d;
        @(posedge CLK);
        #1;
        model_update(rst, ce, d);
        $display("%s rst=%0b ce=%0b d=%h -> seq=%08h off=%02h", tag, rst, ce, d, DISP_SEQ, DISP_OFF);
        check({tag, ".seq"}, DISP_SEQ, model_seq());
        check({tag, ".off"}, {24'h0, DISP_OFF}, {24'h0, model_off()});
    endtask

    task automatic enter(input string tag, input logic [3:0] d);
        step(tag, 1'b0, 1'b1, d);
    endtask

    initial begin
        logic [3:0] wrap_digits[9] = '{4'h8, 4'h0, 4'h3, 4'hB, 4'hA, 4'hD, 4'h9, 4'hF, 4'hC};
        logic [3:0] det_digits[6]  = '{4'h2, 4'h3, 4'h0, 4'hB, 4'h2, 4'h3};
        logic [3:0] pm_digits[5]   = '{4'h2, 4'h2, 4'h3, 4'h0, 4'hB};
        logic [3:0] pool[4]        = '{4'h2, 4'h3, 4'h0, 4'hB};

        // Reset held, then a CE pulse under reset must be discarded.
        for (int i = 0; i < 5; i++) step("rst", 1'b1, 1'b0, 4'h0);
        step("rst_ce", 1'b1, 1'b1, 4'h7);
        check("rst_seq_const", DISP_SEQ, 32'h0);
        check("rst_off_const", {24'h0, DISP_OFF}, 32'hFF);

        enter("basic", 4'h2);
        enter("basic", 4'h3);
        check("basic_seq_const", DISP_SEQ, 32'h0000_0023);
        check("basic_off_const", {24'h0, DISP_OFF}, 32'hFC);

        step("rst", 1'b1, 1'b0, 4'h0);
        foreach (wrap_digits[i]) enter("wrap", wrap_digits[i]);
        check("wrap_seq_const", DISP_SEQ, 32'h03BA_D9FC);
        check("wrap_off_const", {24'h0, DISP_OFF}, 32'h00);

        step("rst", 1'b1, 1'b0, 4'h0);
        foreach (det_digits[i]) enter("det", det_digits[i]);
`ifdef LR3_SEQ_DET_EN
        check("det_seq_const", DISP_SEQ, 32'h0000_230B);
        check("det_off_const", {24'h0, DISP_OFF}, 32'hF0);
`else
        check("det_seq_const", DISP_SEQ, 32'h0023_0B23);
        check("det_off_const", {24'h0, DISP_OFF}, 32'hC0);
`endif

        step("rst", 1'b1, 1'b0, 4'h0);
        foreach (pm_digits[i]) enter("pmatch", pm_digits[i]);
        enter("pmatch", 4'h5);
`ifdef LR3_SEQ_DET_EN
        check("pmatch_seq_const", DISP_SEQ, 32'h0002_230B);
`else
        check("pmatch_seq_const", DISP_SEQ, 32'h0022_30B5);
`endif

        step("rst_mid", 1'b1, 1'b0, 4'h0);
        enter("after_rst", 4'h2);
        check("after_rst_seq_const", DISP_SEQ, 32'h0000_0002);
        check("after_rst_off_const", {24'h0, DISP_OFF}, 32'hFE);

        // Random: digits biased toward the match alphabet, occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic       r = ($urandom_range(0, 39) == 0);
            logic       c = ($urandom_range(0, 9) < 7);
            logic [3:0] d = ($urandom_range(0, 3) != 0) ? pool[$urandom_range(0, 3)]
                                                        : 4'($urandom_range(0, 15));
            step("rand", r, c, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
